// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - shared types and constants for the frame update scheduler
package frame_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } sched_state_e;

  localparam int FRAME_CNT_W     = 16;
  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/rr_first_pick.sv
// rtl/rr_first_pick.sv - combinational rotating first-one finder
// Returns the lowest set mask bit at or above start, wrapping circularly.
module rr_first_pick #(
  parameter int NUM_OBJ = 4,
  localparam int IDX_W = $clog2(NUM_OBJ)
) (
  input  logic [NUM_OBJ-1:0] mask,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               vld
);

  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    logic [IDX_W:0] pos;
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      pos = {1'b0, start} + (IDX_W + 1)'(i);
      if (pos >= (IDX_W + 1)'(NUM_OBJ)) begin
        pos = pos - (IDX_W + 1)'(NUM_OBJ);
      end
      if (mask[pos[IDX_W-1:0]]) begin
        idx = pos[IDX_W-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_update_scheduler.sv
// rtl/frame_update_scheduler.sv - sequences object units through their per-frame update
// Optional FRAME_SCHED_ROTATE_EN: rotate which unit is served first each frame.
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_OBJ        = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  localparam int IDX_W = $clog2(NUM_OBJ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame,
  input  logic                   enable,
  input  logic [NUM_OBJ-1:0]     req,
  input  logic [NUM_OBJ-1:0]     done,
  input  logic                   clr_err,
  output logic [NUM_OBJ-1:0]     grant,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy,
  output logic                   seq_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   timeout_err,
  output logic                   overrun_err
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0]   TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_OBJ-1:0] OH_BASE  = NUM_OBJ'(1);

  sched_state_e           state_q, state_d;
  logic [NUM_OBJ-1:0]     pending_q, pending_d;
  logic [NUM_OBJ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic                   busy_q, busy_d;
  logic                   seq_done_q, seq_done_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   timeout_err_q, timeout_err_d;
  logic                   overrun_err_q, overrun_err_d;
  logic [TMR_W-1:0]       timer_q, timer_d;

  logic [IDX_W-1:0] start_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic             cur_done;
  logic             timeout_evt;
  logic             overrun_evt;

  rr_first_pick #(.NUM_OBJ(NUM_OBJ)) u_pick (
    .mask  (pending_q),
    .start (start_ptr),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  assign cur_done = done[grant_idx_q];

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    seq_done_d    = 1'b0;
    frame_count_d = frame_count_q;
    timer_d       = timer_q;
    timeout_evt   = 1'b0;
    overrun_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame && enable) begin
          pending_d     = req;
          frame_count_d = frame_count_q + 1'b1;
          state_d       = ARB;
        end
      end
      ARB: begin
        overrun_evt = frame;
        if (!pick_vld) begin
          seq_done_d = 1'b1;
          state_d    = IDLE;
        end else begin
          grant_d     = OH_BASE << pick_idx;
          grant_idx_d = pick_idx;
          timer_d     = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        overrun_evt = frame;
        // A stuck unit is released as though it had answered done.
        if (cur_done || timer_q == TMR_LAST) begin
          timeout_evt             = !cur_done;
          grant_d                 = '0;
          pending_d[grant_idx_q]  = 1'b0;
          state_d                 = ARB;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d        = (state_d != IDLE) || seq_done_d;
    timeout_err_d = (timeout_err_q && !clr_err) || timeout_evt;
    overrun_err_d = (overrun_err_q && !clr_err) || overrun_evt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      busy_q        <= 1'b0;
      seq_done_q    <= 1'b0;
      frame_count_q <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      timer_q       <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      busy_q        <= busy_d;
      seq_done_q    <= seq_done_d;
      frame_count_q <= frame_count_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      timer_q       <= timer_d;
    end
  end

`ifdef FRAME_SCHED_ROTATE_EN
  logic [IDX_W-1:0] start_ptr_q, start_ptr_d;
  logic [IDX_W-1:0] first_idx_q, first_idx_d;
  logic             first_vld_q, first_vld_d;

  // Next frame starts just past whoever went first; an empty sequence leaves it alone.
  always_comb begin
    start_ptr_d = start_ptr_q;
    first_idx_d = first_idx_q;
    first_vld_d = first_vld_q;
    if (state_q == IDLE && frame && enable) begin
      first_vld_d = 1'b0;
    end
    if (state_q == ARB) begin
      if (pick_vld && !first_vld_q) begin
        first_idx_d = pick_idx;
        first_vld_d = 1'b1;
      end else if (!pick_vld && first_vld_q) begin
        start_ptr_d = (first_idx_q == IDX_W'(NUM_OBJ - 1)) ? '0 : first_idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_ptr_q <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else begin
      start_ptr_q <= start_ptr_d;
      first_idx_q <= first_idx_d;
      first_vld_q <= first_vld_d;
    end
  end

  assign start_ptr = start_ptr_q;
`else
  assign start_ptr = '0;
`endif

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;
  assign seq_done    = seq_done_q;
  assign frame_count = frame_count_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule
